t05_htree_build_ctrl: RTL and testbench

//  Sequencer for Huffman tree construction. Repeatedly launches a least-value scan over the 384-entry frequency SRAM
//  (256 char slots + 128 internal-node slots), then merges the two least entries. Each merge wipes both chosen slots,

---
 rtl/t05_htree_build_ctrl_pkg.sv | 33 +++
 rtl/t05_htree_build_ctrl_if.sv | 32 +++
 rtl/t05_htree_build_ctrl_memwr.sv | 45 ++++
 rtl/t05_htree_build_ctrl.sv | 153 +++++++++++++++
 tb/tb_t05_htree_build_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/t05_htree_build_ctrl_pkg.sv
// Shared types and constants for the Huffman tree build controller.
// Optional scan watchdog is enabled with HTREE_TIMEOUT_EN.
package t05_htree_pkg;

  localparam int LEAF_CNT    = 256;
  localparam int MAX_NODES   = 128;
  localparam int DATA_W      = 64;
  localparam int TIMEOUT_CYC = 1024;

  localparam logic [8:0] SENTINEL  = 9'h180;
  localparam logic [8:0] NODE_BASE = 9'(LEAF_CNT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN,
    S_WAIT,
    S_CHECK,
    S_WIPE1,
    S_WIPE2,
    S_WRSUM,
    S_NODE,
    S_DONE,
    S_ERR
  } state_t;

  function automatic logic [8:0] entry_addr(
    input logic [8:0] e
  );
    return e[8] ? NODE_BASE + {1'b0, e[7:0]}
                : {1'b0, e[7:0]};
  endfunction

endpackage

// File: rtl/t05_htree_build_ctrl_if.sv
// Scan-engine and SRAM-write bundle of the tree builder.
// Master side is the controller, slave side is FLV + SRAM.
interface t05_htree_build_ctrl_if;
  import t05_htree_pkg::*;

  logic              flv_start;
  logic              flv_done;
  logic [8:0]        flv_least1;
  logic [8:0]        flv_least2;
  logic [DATA_W-1:0] flv_sum;
  logic              mem_req;
  logic [8:0]        mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;

  modport master (
    output flv_start, mem_req,
    output mem_addr, mem_wdata,
    input  flv_done, flv_least1,
    input  flv_least2, flv_sum,
    input  mem_ack
  );

  modport slave (
    input  flv_start, mem_req,
    input  mem_addr, mem_wdata,
    output flv_done, flv_least1,
    output flv_least2, flv_sum,
    output mem_ack
  );

endinterface

// File: rtl/t05_htree_build_ctrl_memwr.sv
// SRAM write holder: latches one transfer on i_go and keeps
// req/addr/data stable until the cycle the SRAM acks it.
module t05_htree_memwr
  import t05_htree_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_go,
  input  logic [8:0]        i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ack,
  output logic              o_req,
  output logic [8:0]        o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_fin
);

  logic              r_req;
  logic [8:0]        r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_fin;

  assign w_fin = r_req & i_ack;

  // hold the transfer from go until ack
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_req  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (i_go) begin
      r_req  <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
    end else if (w_fin) begin
      r_req  <= 1'b0;
    end
  end

  assign o_req  = r_req;
  assign o_addr = r_addr;
  assign o_data = r_data;
  assign o_fin  = w_fin;

endmodule

// File: rtl/t05_htree_build_ctrl.sv
// Huffman tree build sequencer: scan, merge, record nodes.
// Define HTREE_TIMEOUT_EN to add a watchdog on the scan wait.
module t05_htree_build_ctrl
  import t05_htree_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  t05_htree_build_ctrl_if.master bus,
  output logic       node_wr,
  output logic [6:0] node_idx,
  output logic [8:0] node_left,
  output logic [8:0] node_right,
  output logic       busy,
  output logic       done,
  output logic [8:0] root,
  output logic       err
);

  state_t            r_state;
  state_t            w_nxt;
  logic [8:0]        r_l1;
  logic [8:0]        r_l2;
  logic [DATA_W-1:0] r_sum;
  logic [7:0]        r_k;
  logic [8:0]        r_root;
  logic              r_err;
  logic              w_go;
  logic [8:0]        w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_req;
  logic              w_fin;
`ifdef HTREE_TIMEOUT_EN
  logic [10:0]       r_tcnt;
`endif

  // state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  // next state and SRAM transfer launch
  always_comb begin
    w_nxt  = r_state;
    w_go   = 1'b0;
    w_addr = '0;
    w_data = '0;
    unique case (r_state)
      S_IDLE:  if (start) w_nxt = S_SCAN;
      S_SCAN:  w_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.flv_done) w_nxt = S_CHECK;
`ifdef HTREE_TIMEOUT_EN
        else if (r_tcnt == 11'(TIMEOUT_CYC - 1))
          w_nxt = S_ERR;
`endif
      end
      S_CHECK: begin
        if (r_l2 == SENTINEL)
          w_nxt = S_DONE;
        else if (r_k == 8'(MAX_NODES))
          w_nxt = S_ERR;
        else
          w_nxt = S_WIPE1;
      end
      S_WIPE1: begin
        w_addr = entry_addr(r_l1);
        w_go   = ~w_req;
        if (w_fin) w_nxt = S_WIPE2;
      end
      S_WIPE2: begin
        w_addr = entry_addr(r_l2);
        w_go   = ~w_req;
        if (w_fin) w_nxt = S_WRSUM;
      end
      S_WRSUM: begin
        w_addr = NODE_BASE + {2'b00, r_k[6:0]};
        w_data = r_sum;
        w_go   = ~w_req;
        if (w_fin) w_nxt = S_NODE;
      end
      S_NODE:  w_nxt = S_SCAN;
      S_DONE:  w_nxt = S_IDLE;
      S_ERR:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // merge bookkeeping: latched scan result, count, root, error
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_l1   <= SENTINEL;
      r_l2   <= SENTINEL;
      r_sum  <= '0;
      r_k    <= '0;
      r_root <= SENTINEL;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_k    <= '0;
        r_err  <= 1'b0;
        r_root <= SENTINEL;
      end
      if (r_state == S_WAIT && bus.flv_done) begin
        r_l1  <= bus.flv_least1;
        r_l2  <= bus.flv_least2;
        r_sum <= bus.flv_sum;
      end
      if (r_state == S_CHECK && w_nxt == S_DONE)
        r_root <= r_l1;
      if (r_state != S_ERR && w_nxt == S_ERR)
        r_err <= 1'b1;
      if (r_state == S_NODE)
        r_k <= r_k + 8'd1;
    end
  end

`ifdef HTREE_TIMEOUT_EN
  // scan watchdog, restarted by every scan launch
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                  r_tcnt <= '0;
    else if (r_state == S_SCAN) r_tcnt <= '0;
    else if (r_state == S_WAIT) r_tcnt <= r_tcnt + 11'd1;
  end
`endif

  t05_htree_memwr u_memwr (
    .clk    (clk),
    .nrst   (nrst),
    .i_go   (w_go),
    .i_addr (w_addr),
    .i_data (w_data),
    .i_ack  (bus.mem_ack),
    .o_req  (w_req),
    .o_addr (bus.mem_addr),
    .o_data (bus.mem_wdata),
    .o_fin  (w_fin)
  );

  assign bus.mem_req   = w_req;
  assign bus.flv_start = (r_state == S_SCAN);
  assign node_wr    = (r_state == S_NODE);
  assign node_idx   = node_wr ? r_k[6:0] : 7'd0;
  assign node_left  = node_wr ? r_l1 : 9'd0;
  assign node_right = node_wr ? r_l2 : 9'd0;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE) ||
                (r_state == S_ERR);
  assign root = r_root;
  assign err  = r_err;

endmodule

// File: tb/tb_t05_htree_build_ctrl.sv
// Bench for the Huffman tree build controller: models the
// scan engine and SRAM, compares against a Huffman reference.
module tb_t05_htree_build_ctrl;
  import t05_htree_pkg::*;

  logic       clk;
  logic       nrst;
  logic       start;
  logic       node_wr;
  logic [6:0] node_idx;
  logic [8:0] node_left;
  logic [8:0] node_right;
  logic       busy;
  logic       done;
  logic [8:0] root;
  logic       err;

  t05_htree_build_ctrl_if bus ();

  t05_htree_build_ctrl dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .bus        (bus.master),
    .node_wr    (node_wr),
    .node_idx   (node_idx),
    .node_left  (node_left),
    .node_right (node_right),
    .busy       (busy),
    .done       (done),
    .root       (root),
    .err        (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fd_cyc = 0;
  bit flv_mute = 0;

  logic [63:0] mem [384];
  logic [63:0] saved [384];
  logic [8:0]  exp_maddr [$];
  logic [63:0] exp_mdata [$];
  logic [24:0] exp_node [$];
  int          ack_dly_q [$];
  logic [8:0]  exp_root;
  logic        exp_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // two smallest nonzero entries, lower address wins ties
  task automatic pick2(input logic [63:0] a [384],
                       output int m1, output int m2);
    m1 = -1;
    m2 = -1;
    for (int i = 0; i < 384; i++) begin
      if (a[i] != 0) begin
        if (m1 < 0 || a[i] < a[m1]) begin
          m2 = m1;
          m1 = i;
        end else if (m2 < 0 || a[i] < a[m2]) begin
          m2 = i;
        end
      end
    end
  endtask

  function automatic logic [8:0] code(input int i);
    return (i < 0) ? SENTINEL : 9'(i);
  endfunction

  // Huffman build over the loaded leaves
  task automatic ref_model();
    logic [63:0] v [384];
    int k;
    int m1;
    int m2;
    for (int i = 0; i < 384; i++) v[i] = mem[i];
    k = 0;
    exp_err = 1'b0;
    exp_root = SENTINEL;
    while (1) begin
      pick2(v, m1, m2);
      if (m1 < 0) break;
      if (m2 < 0) begin
        exp_root = code(m1);
        break;
      end
      if (k == MAX_NODES) begin
        exp_err = 1'b1;
        break;
      end
      exp_maddr.push_back(code(m1));
      exp_mdata.push_back(64'd0);
      exp_maddr.push_back(code(m2));
      exp_mdata.push_back(64'd0);
      exp_maddr.push_back(9'(256 + k));
      exp_mdata.push_back(v[m1] + v[m2]);
      exp_node.push_back({7'(k), code(m1), code(m2)});
      v[256 + k] = v[m1] + v[m2];
      v[m1] = 0;
      v[m2] = 0;
      k++;
    end
  endtask

  task automatic load(input int n);
    int placed;
    int a;
    for (int i = 0; i < 384; i++) mem[i] = 64'd0;
    placed = 0;
    while (placed < n) begin
      a = $urandom_range(0, 255);
      if (mem[a] == 0) begin
        mem[a] = 64'($urandom_range(1, 1 << 20));
        placed++;
      end
    end
  endtask

  // scan engine model
  initial begin : flv_model
    bit pend;
    int lat;
    int m1;
    int m2;
    pend = 0;
    lat = 0;
    bus.flv_done = 1'b0;
    bus.flv_least1 = SENTINEL;
    bus.flv_least2 = SENTINEL;
    bus.flv_sum = 64'd0;
    forever begin
      @(negedge clk);
      bus.flv_done = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          pick2(mem, m1, m2);
          bus.flv_least1 = code(m1);
          bus.flv_least2 = code(m2);
          bus.flv_sum = (m1 < 0 ? 64'd0 : mem[m1]) +
                        (m2 < 0 ? 64'd0 : mem[m2]);
          bus.flv_done = 1'b1;
          fd_cyc = cyc;
          pend = 0;
        end else begin
          lat--;
        end
      end else if (bus.flv_start === 1'b1 && !flv_mute) begin
        pend = 1;
        lat = $urandom_range(0, 3);
      end else if (!busy && $urandom_range(0, 7) == 0) begin
        bus.flv_least1 = 9'h0aa;
        bus.flv_least2 = 9'h055;
        bus.flv_sum = 64'hdead;
        bus.flv_done = 1'b1;
      end
    end
  end

  // SRAM model with scoreboard on every accepted write
  initial begin : sram_model
    bit inx;
    bit just_ack;
    int cnt;
    int dly;
    logic [8:0] sa;
    logic [63:0] sd;
    inx = 0;
    just_ack = 0;
    cnt = 0;
    dly = 0;
    sa = '0;
    sd = '0;
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (just_ack) begin
        chk("req_gap", 64'(bus.mem_req), 64'd0);
        just_ack = 0;
      end
      if (bus.mem_req === 1'b1) begin
        if (!inx) begin
          inx = 1;
          cnt = 0;
          dly = (ack_dly_q.size() > 0) ?
                ack_dly_q.pop_front() :
                $urandom_range(0, 2);
          sa = bus.mem_addr;
          sd = bus.mem_wdata;
        end
        if (cnt == dly) begin
          bus.mem_ack = 1'b1;
          inx = 0;
          just_ack = 1;
          chk("addr_stable", 64'(bus.mem_addr), 64'(sa));
          chk("data_stable", bus.mem_wdata, sd);
          if (exp_maddr.size() == 0) begin
            chk("mem_extra", 64'(bus.mem_addr), 64'h1ff);
          end else begin
            chk("mem_addr", 64'(bus.mem_addr),
                64'(exp_maddr.pop_front()));
            chk("mem_data", bus.mem_wdata,
                exp_mdata.pop_front());
          end
          if (bus.mem_addr < 9'd384)
            mem[bus.mem_addr] = bus.mem_wdata;
        end else begin
          cnt++;
          bus.mem_ack = 1'b0;
        end
      end else begin
        inx = 0;
        bus.mem_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // node-table scoreboard
  initial begin : node_mon
    forever begin
      @(negedge clk);
      if (node_wr === 1'b1) begin
        if (exp_node.size() == 0)
          chk("node_extra", 64'(node_idx), 64'h7f);
        else
          chk("node", 64'({node_idx, node_left, node_right}),
              64'(exp_node.pop_front()));
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_build(input bit dbl);
    bit got;
    ref_model();
    pulse_start();
    chk("busy_on", 64'(busy), 64'd1);
    chk("flv_start", 64'(bus.flv_start), 64'd1);
    if (dbl) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = done;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    chk("done_seen", 64'(got), 64'd1);
    if (got) begin
      chk("err_at_done", 64'(err), 64'(exp_err));
      chk("root_at_done", 64'(root), 64'(exp_root));
      if (!exp_err)
        chk("done_lat", 64'(cyc - fd_cyc), 64'd2);
    end
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_off", 64'(busy), 64'd0);
    chk("root_hold", 64'(root), 64'(exp_root));
    chk("err_hold", 64'(err), 64'(exp_err));
    chk("mem_left", 64'(exp_maddr.size()), 64'd0);
    chk("node_left", 64'(exp_node.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_root"}, 64'(root), 64'h180);
    chk({tag, "_req"}, 64'(bus.mem_req), 64'd0);
    chk({tag, "_nwr"}, 64'(node_wr), 64'd0);
    chk({tag, "_fst"}, 64'(bus.flv_start), 64'd0);
  endtask

  initial begin : main
    bit got;
    start = 1'b0;
    nrst = 1'b0;
    for (int i = 0; i < 384; i++) mem[i] = 64'd0;
    #7;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 384; i++) mem[i] = 64'd0;
    mem[65] = 64'd3;
    mem[66] = 64'd5;
    run_build(0);
    chk("two_leaf_root", 64'(root), 64'h100);
    chk("two_leaf_sum", mem[256], 64'd8);

    load(0);
    run_build(0);

    load(1);
    run_build(0);

    load(3);
    ack_dly_q.push_back(5);
    run_build(0);

    for (int t = 0; t < 4; t++) begin
      load($urandom_range(2, 40));
      run_build(t[0]);
    end

    load(129);
    run_build(0);
    load(130);
    run_build(0);

    for (int i = 0; i < 384; i++) mem[i] = 64'd0;
    mem[10] = 64'd7;
    mem[20] = 64'd9;
    for (int i = 0; i < 384; i++) saved[i] = mem[i];
    ack_dly_q.push_back(0);
    ack_dly_q.push_back(0);
    ack_dly_q.push_back(1000);
    ref_model();
    pulse_start();
    got = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      got = (bus.mem_req === 1'b1) &&
            (bus.mem_addr === 9'd256);
    end
    chk("wrsum_seen", 64'(got), 64'd1);
    repeat (2) @(negedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    ack_dly_q.delete();
    exp_maddr.delete();
    exp_mdata.delete();
    exp_node.delete();
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 384; i++) mem[i] = saved[i];
    run_build(0);
    chk("rebuild_root", 64'(root), 64'h100);

    load(4);
    flv_mute = 1;
    pulse_start();
    got = 0;
    for (int i = 0; i < 1100 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
`ifdef HTREE_TIMEOUT_EN
    chk("timeout_done", 64'(got), 64'd1);
    chk("timeout_err", 64'(err), 64'd1);
`else
    chk("no_timeout", 64'(got), 64'd0);
    chk("wait_busy", 64'(busy), 64'd1);
`endif
    @(negedge clk);
    nrst = 1'b0;
    flv_mute = 0;
    exp_maddr.delete();
    exp_mdata.delete();
    exp_node.delete();
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check_idle_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
